// File: rtl/sa_ram_pkg.sv
// sa_ram_pkg
//   Shared definitions for the SA buffer RAM models: read-during-write mode
//   encoding, power-bus bit positions and the write-mask lane mapping helper.
package sa_ram_pkg;

  typedef enum logic {
    RDW_WRITE_FIRST = 1'b0,
    RDW_READ_FIRST  = 1'b1
  } rdw_mode_e;

  localparam int PD_SLEEP_BIT = 0;

  // Maps a data bit to the write-mask lane that enables it.
  // Each lane covers dw/mw contiguous bits, lane 0 at the LSBs.
  function automatic int mask_lane_of(input int bit_idx, input int dw, input int mw);
    return bit_idx / (dw / mw);
  endfunction

endpackage

// File: rtl/sa_ram_rwsp_core.sv
// sa_ram_rwsp_core
//   Storage array with masked write, optional READ_FIRST bypass register and
//   out-of-range read gating. Read data is combinational from the captured
//   read address.
// Ports
//   clk, rstn   clock, async active-low reset (bypass state only)
//   i_we/i_wa   write enable (already sleep-gated) / write address
//   i_wmask     per-lane write enable
//   i_di        write data
//   i_re/i_ra   read enable (already sleep-gated) / current read address
//   i_ra_d      captured read address
//   o_rdata     array read data for i_ra_d (zero when out of range)
module sa_ram_rwsp_core
  import sa_ram_pkg::*;
#(
  parameter int DW       = 11,
  parameter int DEPTH    = 256,
  parameter int AW       = 8,
  parameter int MW       = 1,
  parameter int RDW_MODE = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_we,
  input  logic [AW-1:0] i_wa,
  input  logic [MW-1:0] i_wmask,
  input  logic [DW-1:0] i_di,
  input  logic          i_re,
  input  logic [AW-1:0] i_ra,
  input  logic [AW-1:0] i_ra_d,
  output logic [DW-1:0] o_rdata
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] w_bitmask;
  logic [DW-1:0] w_arr;
  logic          w_wa_ok;
  logic          w_rad_ok;

  assign w_wa_ok  = ({1'b0, i_wa}   < LP_DEPTH);
  assign w_rad_ok = ({1'b0, i_ra_d} < LP_DEPTH);

  for (genvar g = 0; g < DW; g++) begin : g_mask
    assign w_bitmask[g] = i_wmask[mask_lane_of(g, DW, MW)];
  end

  always_ff @(posedge clk) begin
    if (i_we && w_wa_ok) begin
      r_mem[i_wa] <= (r_mem[i_wa] & ~w_bitmask) | (i_di & w_bitmask);
    end
  end

  if (RDW_MODE == int'(RDW_READ_FIRST)) begin : g_rf
    logic          r_byp_vld;
    logic [DW-1:0] r_byp_data;
    logic          w_coll;

    assign w_coll = i_re && i_we && (i_ra == i_wa) && w_wa_ok;

    // Bypass holds the pre-write word of a colliding read. It must drop as
    // soon as the array becomes the truth again: a new read, or any later
    // write that lands on the captured address.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_byp_vld  <= 1'b0;
        r_byp_data <= '0;
      end else if (w_coll) begin
        r_byp_vld  <= 1'b1;
        r_byp_data <= r_mem[i_wa];
      end else if (i_re || (i_we && (i_wa == i_ra_d))) begin
        r_byp_vld  <= 1'b0;
      end
    end

    assign w_arr = r_byp_vld ? r_byp_data : r_mem[i_ra_d];
  end else begin : g_wf
    logic w_unused_wf;
    assign w_unused_wf = ^{i_re, i_ra, rstn};
    assign w_arr = r_mem[i_ra_d];
  end

  assign o_rdata = w_rad_ok ? w_arr : '0;

endmodule

// File: rtl/sa_ram_rwsp_param.sv
// sa_ram_rwsp_param
//   Parametrised 1R1W synchronous RAM for the SA operand/psum buffers.
//   Captures the read address, presents data either registered (gated by
//   ore) or directly, flags same-address read/write collisions and honours
//   a functional sleep bit on the power bus.
// Ports
//   clk, rstn       clock, async active-low reset
//   ra, re          read address / read enable
//   ore             output-register enable (OUT_REG=1 only)
//   dout, dout_vld  read data / read data valid
//   wa, we          write address / write enable
//   wmask, di       per-lane write enable / write data
//   rw_collision    one-cycle pulse after a same-address re&we edge
//   pwrbus_ram_pd   power bus; bit PD_SLEEP_BIT puts the RAM to sleep
module sa_ram_rwsp_param
  import sa_ram_pkg::*;
#(
  parameter int   DW       = 11,
  parameter int   DEPTH    = 256,
  parameter int   AW       = $clog2(DEPTH),
  parameter int   MW       = 1,
  parameter int   RDW_MODE = 0,
  parameter int   OUT_REG  = 1,
  parameter logic FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] ra,
  input  logic          re,
  input  logic          ore,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [MW-1:0] wmask,
  input  logic [DW-1:0] di,
  output logic          rw_collision,
  input  logic [31:0]   pwrbus_ram_pd
);

  logic          w_sleep;
  logic          w_re;
  logic          w_we;
  logic          w_coll_nxt;
  logic [DW-1:0] w_rdata;
  logic [AW-1:0] r_ra_d;
  logic          r_rvld_d;
  logic          r_coll;
  logic          w_unused_pd;

  assign w_unused_pd = ^pwrbus_ram_pd;

  assign w_sleep    = pwrbus_ram_pd[PD_SLEEP_BIT];
  assign w_re       = re && !w_sleep;
  assign w_we       = we && !w_sleep;
  assign w_coll_nxt = w_re && w_we && (ra == wa);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ra_d   <= '0;
      r_rvld_d <= 1'b0;
    end else begin
      r_rvld_d <= w_re;
      if (w_re) begin
        r_ra_d <= ra;
      end
    end
  end

  sa_ram_rwsp_core #(
    .DW       (DW),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .MW       (MW),
    .RDW_MODE (RDW_MODE)
  ) u_core (
    .clk     (clk),
    .rstn    (rstn),
    .i_we    (w_we),
    .i_wa    (wa),
    .i_wmask (wmask),
    .i_di    (di),
    .i_re    (w_re),
    .i_ra    (ra),
    .i_ra_d  (r_ra_d),
    .o_rdata (w_rdata)
  );

  if (OUT_REG != 0) begin : g_oreg
    logic [DW-1:0] r_dout;
    logic          r_dout_vld;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_dout     <= '0;
        r_dout_vld <= 1'b0;
      end else if (ore) begin
        r_dout     <= w_rdata;
        r_dout_vld <= r_rvld_d;
      end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
  end else begin : g_nreg
    logic w_unused_ore;
    assign w_unused_ore = ore;
    assign dout         = w_rdata;
    assign dout_vld     = r_rvld_d;
  end

  // When forced, the flag register has no reset so contention is still
  // evaluated on every edge while rstn is held low.
  if (FORCE_CONTENTION_ASSERTION_RESET_ACTIVE) begin : g_coll_free
    always_ff @(posedge clk) begin
      r_coll <= w_coll_nxt;
    end
  end else begin : g_coll_rst
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_coll <= 1'b0;
      end else begin
        r_coll <= w_coll_nxt;
      end
    end
  end

  assign rw_collision = r_coll;

endmodule

// File: tb/tb_sa_ram_rwsp_param.sv
// tb_sa_ram_rwsp_param
//   Two instances share one stimulus stream: A is WRITE_FIRST with the
//   output register, B is READ_FIRST with direct output. Directed sequences
//   cover reset, latency/hold, masking, collision, sleep and range limits;
//   a randomized phase is scored against a word-level memory model.
module tb_sa_ram_rwsp_param;

  localparam int DW = 16;
  localparam int DEPTH = 200;
  localparam int AW = 8;
  localparam int MW = 2;

  logic          clk;
  logic          rstn;
  logic [AW-1:0] ra;
  logic          re;
  logic          ore;
  logic [AW-1:0] wa;
  logic          we;
  logic [MW-1:0] wmask;
  logic [DW-1:0] di;
  logic [31:0]   pd;

  logic [DW-1:0] dout_a, dout_b;
  logic          vld_a, vld_b;
  logic          coll_a, coll_b;

  sa_ram_rwsp_param #(
    .DW(DW), .DEPTH(DEPTH), .AW(AW), .MW(MW), .RDW_MODE(0), .OUT_REG(1),
    .FORCE_CONTENTION_ASSERTION_RESET_ACTIVE(1'b0)
  ) u_a (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout_a),
    .dout_vld(vld_a), .wa(wa), .we(we), .wmask(wmask), .di(di),
    .rw_collision(coll_a), .pwrbus_ram_pd(pd)
  );

  sa_ram_rwsp_param #(
    .DW(DW), .DEPTH(DEPTH), .AW(AW), .MW(MW), .RDW_MODE(1), .OUT_REG(0),
    .FORCE_CONTENTION_ASSERTION_RESET_ACTIVE(1'b0)
  ) u_b (
    .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout_b),
    .dout_vld(vld_b), .wa(wa), .we(we), .wmask(wmask), .di(di),
    .rw_collision(coll_b), .pwrbus_ram_pd(pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: plain word memory, reads beyond DEPTH give zero.
  typedef struct {
    int          cyc;
    logic [15:0] d;
  } exp_t;

  logic [15:0] mem_m [DEPTH];
  exp_t        q_a[$];
  exp_t        q_b[$];
  int          cyc = 0;
  logic        exp_coll = 1'b0;
  bit          mon_en = 1'b0;

  function automatic logic [15:0] m_rd(input logic [7:0] a);
    if (int'(a) < DEPTH) return mem_m[a];
    return 16'h0;
  endfunction

  always @(posedge clk) begin : model
    logic [15:0] pre_w, post_w;
    logic        do_rd, do_wr, hit;
    cyc = cyc + 1;
    if (rstn) begin
      do_rd = re && !pd[0];
      do_wr = we && !pd[0];
      pre_w = m_rd(ra);
      if (do_wr && int'(wa) < DEPTH) begin
        if (wmask[0]) mem_m[wa][7:0]  = di[7:0];
        if (wmask[1]) mem_m[wa][15:8] = di[15:8];
      end
      post_w   = m_rd(ra);
      hit      = do_rd && do_wr && (ra == wa);
      exp_coll = hit;
      if (do_rd) begin
        q_a.push_back('{cyc + 1, post_w});
        q_b.push_back('{cyc, hit ? pre_w : post_w});
      end
    end else begin
      exp_coll = 1'b0;
    end
  end

  // Monitor: each expected read carries the cycle in which it must appear.
  always @(negedge clk) begin : monitor
    logic ev;
    if (mon_en) begin
      while (q_a.size() > 0 && q_a[0].cyc < cyc) void'(q_a.pop_front());
      while (q_b.size() > 0 && q_b[0].cyc < cyc) void'(q_b.pop_front());
      ev = (q_a.size() > 0) && (q_a[0].cyc == cyc);
      chk("A_vld", 32'(vld_a), 32'(ev));
      if (ev) begin
        chk("A_dout", 32'(dout_a), 32'(q_a[0].d));
        void'(q_a.pop_front());
      end
      ev = (q_b.size() > 0) && (q_b[0].cyc == cyc);
      chk("B_vld", 32'(vld_b), 32'(ev));
      if (ev) begin
        chk("B_dout", 32'(dout_b), 32'(q_b[0].d));
        void'(q_b.pop_front());
      end
      chk("A_coll", 32'(coll_a), 32'(exp_coll));
      chk("B_coll", 32'(coll_b), 32'(exp_coll));
    end
  end

  function automatic logic [7:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 5) return 8'($urandom_range(0, 7));
    if (r < 9) return 8'($urandom_range(0, DEPTH - 1));
    return 8'($urandom_range(DEPTH, 255));
  endfunction

  initial begin
    rstn = 1'b0; re = 1'b0; we = 1'b0; ore = 1'b0;
    ra = '0; wa = '0; wmask = '0; di = '0; pd = '0;

    repeat (3) @(negedge clk);
    chk("rst_A_dout", 32'(dout_a), 0);
    chk("rst_A_vld", 32'(vld_a), 0);
    chk("rst_A_coll", 32'(coll_a), 0);
    chk("rst_B_vld", 32'(vld_b), 0);
    chk("rst_B_coll", 32'(coll_b), 0);
    rstn = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; wa = 8'(i); wmask = 2'b11; di = 16'($urandom);
      @(negedge clk);
    end
    we = 1'b0;

    // Latency and output hold
    we = 1'b1; wa = 8'd3; di = 16'h05A5; wmask = 2'b11; ore = 1'b0;
    @(negedge clk);
    we = 1'b0; re = 1'b1; ra = 8'd3;
    @(negedge clk);
    chk("lat_B_dout", 32'(dout_b), 32'h05A5);
    chk("lat_B_vld", 32'(vld_b), 1);
    re = 1'b0; ore = 1'b1;
    @(negedge clk);
    chk("lat_A_dout", 32'(dout_a), 32'h05A5);
    chk("lat_A_vld", 32'(vld_a), 1);
    chk("lat_B_vld_drop", 32'(vld_b), 0);
    ore = 1'b0; we = 1'b1; wa = 8'd3; di = 16'h1111;
    @(negedge clk);
    chk("hold_A_dout", 32'(dout_a), 32'h05A5);
    chk("hold_A_vld", 32'(vld_a), 1);
    we = 1'b0; ore = 1'b1;
    @(negedge clk);
    chk("drop_A_vld", 32'(vld_a), 0);

    // Masked write: only the low lane changes
    we = 1'b1; wa = 8'd7; di = 16'hFFFF; wmask = 2'b11;
    @(negedge clk);
    di = 16'h1234; wmask = 2'b01;
    @(negedge clk);
    we = 1'b0; re = 1'b1; ra = 8'd7;
    @(negedge clk);
    chk("mask_B", 32'(dout_b), 32'hFF34);
    re = 1'b0;
    @(negedge clk);
    chk("mask_A", 32'(dout_a), 32'hFF34);

    // Same-edge collision, then a later write to the captured address
    we = 1'b1; wa = 8'd9; di = 16'h0011; wmask = 2'b11;
    @(negedge clk);
    di = 16'h07FF; re = 1'b1; ra = 8'd9;
    @(negedge clk);
    chk("coll_B_dout", 32'(dout_b), 32'h0011);
    chk("coll_A_flag", 32'(coll_a), 1);
    chk("coll_B_flag", 32'(coll_b), 1);
    di = 16'h0ABC; re = 1'b0;
    @(negedge clk);
    chk("coll_A_dout", 32'(dout_a), 32'h07FF);
    chk("coll_A_pulse", 32'(coll_a), 0);
    chk("coll_B_pulse", 32'(coll_b), 0);
    chk("follow_B", 32'(dout_b), 32'h0ABC);
    we = 1'b0;

    // Sleep: write and read ignored, no collision
    we = 1'b1; wa = 8'd4; di = 16'h1357;
    @(negedge clk);
    pd = 32'h1; di = 16'h0003; re = 1'b1; ra = 8'd4;
    @(negedge clk);
    chk("sleep_A_coll", 32'(coll_a), 0);
    chk("sleep_B_coll", 32'(coll_b), 0);
    chk("sleep_B_vld", 32'(vld_b), 0);
    pd = '0; we = 1'b0;
    @(negedge clk);
    chk("sleep_B_dout", 32'(dout_b), 32'h1357);
    re = 1'b0;
    @(negedge clk);
    chk("sleep_A_dout", 32'(dout_a), 32'h1357);

    // Range limits
    we = 1'b1; wa = 8'd255; di = 16'hBEEF;
    @(negedge clk);
    wa = 8'd199; di = 16'hC0DE;
    @(negedge clk);
    we = 1'b0; re = 1'b1; ra = 8'd255;
    @(negedge clk);
    chk("oor_B_dout", 32'(dout_b), 0);
    chk("oor_B_vld", 32'(vld_b), 1);
    ra = 8'd199;
    @(negedge clk);
    chk("oor_A_dout", 32'(dout_a), 0);
    chk("oor_A_vld", 32'(vld_a), 1);
    chk("top_B", 32'(dout_b), 32'hC0DE);
    re = 1'b0;
    @(negedge clk);
    chk("top_A", 32'(dout_a), 32'hC0DE);

    // Randomized phase under the scoreboard
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      re    = ($urandom_range(0, 3) != 0);
      ra    = pick_addr();
      we    = ($urandom_range(0, 2) != 0);
      wa    = ($urandom_range(0, 3) == 0) ? ra : pick_addr();
      wmask = 2'($urandom_range(0, 3));
      di    = 16'($urandom);
      pd    = {31'($urandom), ($urandom_range(0, 15) == 0)};
      @(negedge clk);
    end
    re = 1'b0; we = 1'b0; pd = '0;
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    chk("queues_drained", 32'(q_a.size() + q_b.size()), 0);

    // Asynchronous reset in the middle of a colliding read
    ore = 1'b1; re = 1'b1; we = 1'b1; ra = 8'd10; wa = 8'd10; di = 16'h4321; wmask = 2'b11;
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_A_dout", 32'(dout_a), 0);
    chk("arst_A_vld", 32'(vld_a), 0);
    chk("arst_A_coll", 32'(coll_a), 0);
    chk("arst_B_vld", 32'(vld_b), 0);
    chk("arst_B_coll", 32'(coll_b), 0);
    @(posedge clk);
    #1;
    chk("arst_hold_A_vld", 32'(vld_a), 0);
    chk("arst_hold_B_vld", 32'(vld_b), 0);
    @(negedge clk);
    rstn = 1'b1; we = 1'b1; wa = 8'd20; di = 16'h2468; wmask = 2'b11;
    @(negedge clk);
    we = 1'b0; re = 1'b1; ra = 8'd20;
    @(negedge clk);
    chk("rel_wr_B", 32'(dout_b), 32'h2468);
    re = 1'b0;
    @(negedge clk);
    chk("rel_wr_A", 32'(dout_a), 32'h2468);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
